// File: rtl/seq_divider.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : seq_divider
//  Description : Sequential unsigned restoring (shift-subtract) divider that
//                produces one quotient bit per clock. It performs the mantissa
//                divide step of the floating-point divide path, and a
//                start/done handshake lets the FP sequencer launch an
//                operation and wait for the result.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH        operand/result width in bits (>= 2)
//  Ports
//    clk          in   1      clock, rising edge
//    reset        in   1      asynchronous, active-low reset
//    start        in   1      launch request, sampled only while idle
//    dividend     in   WIDTH  numerator, captured on an accepted start
//    divisor      in   WIDTH  denominator, captured on an accepted start
//    busy         out  1      high while an operation is in flight
//    done         out  1      one-cycle pulse: results valid
//    quotient     out  WIDTH  unsigned quotient, held until the next result
//    remainder    out  WIDTH  unsigned remainder, held until the next result
//    div_by_zero  out  1      set with done when divisor was zero
// ============================================================================
module seq_divider #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] C_COUNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] C_COUNT_LAST = CW'(1);

    logic [1:0]       r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_divisor;
    // The partial remainder is always below the divisor once restored, so its
    // extra top bit is always zero and is not stored.
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_q;
    logic             r_dz;

    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_by_zero;
    logic             r_done;

    logic [WIDTH:0]   w_trial;
    logic             w_sub_ok;
    logic [WIDTH-1:0] w_diff;

    // Trial value: partial remainder shifted left with the next dividend bit.
    assign w_trial  = {r_p, r_q[WIDTH-1]};
    assign w_sub_ok = (w_trial >= {1'b0, r_divisor});
    // When the subtract is taken the true difference is below the divisor,
    // so the low WIDTH bits hold it exactly.
    assign w_diff   = w_trial[WIDTH-1:0] - r_divisor;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_count       <= '0;
            r_divisor     <= '0;
            r_p           <= '0;
            r_q           <= '0;
            r_dz          <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_divisor <= divisor;
                        r_count   <= C_COUNT_INIT;
                        if (divisor == '0) begin
                            // Divide by zero skips the iterations entirely:
                            // quotient saturates, remainder is the dividend.
                            r_dz    <= 1'b1;
                            r_q     <= '1;
                            r_p     <= dividend;
                            r_state <= S_DONE;
                        end else begin
                            r_dz    <= 1'b0;
                            r_q     <= dividend;
                            r_p     <= '0;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_p     <= w_sub_ok ? w_diff : w_trial[WIDTH-1:0];
                    r_q     <= {r_q[WIDTH-2:0], w_sub_ok};
                    r_count <= r_count - 1'b1;
                    if (r_count == C_COUNT_LAST) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_quotient    <= r_q;
                    r_remainder   <= r_p;
                    r_div_by_zero <= r_dz;
                    r_done        <= 1'b1;
                    r_state       <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_seq_divider
//  Description : Self-checking bench for seq_divider with directed vectors,
//                using an 8-bit and a 24-bit instance on a shared clock/reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        reset;

    logic        s8;
    logic [7:0]  a8, b8, q8, r8;
    logic        busy8, done8, dz8;

    logic        s24;
    logic [23:0] a24, b24, q24, r24;
    logic        busy24, done24, dz24;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_divider #(.WIDTH(8)) u_dut8 (
        .clk         (clk),
        .reset       (reset),
        .start       (s8),
        .dividend    (a8),
        .divisor     (b8),
        .busy        (busy8),
        .done        (done8),
        .quotient    (q8),
        .remainder   (r8),
        .div_by_zero (dz8)
    );

    seq_divider #(.WIDTH(24)) u_dut24 (
        .clk         (clk),
        .reset       (reset),
        .start       (s24),
        .dividend    (a24),
        .divisor     (b24),
        .busy        (busy24),
        .done        (done24),
        .quotient    (q24),
        .remainder   (r24),
        .div_by_zero (dz24)
    );

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input logic edz,
                        input int elat);
        int cnt;
        int bcnt;
        a8 = a; b8 = b; s8 = 1'b1;
        tick();
        s8 = 1'b0;
        cnt = 0; bcnt = 0;
        while (!done8 && cnt < 60) begin
            if (busy8) bcnt++;
            tick();
            cnt++;
        end
        check_value({tag, " latency"}, 64'(cnt), 64'(elat));
        check_value({tag, " busy_cycles"}, 64'(bcnt), 64'(elat));
        check_value({tag, " quotient"}, 64'(q8), 64'(eq));
        check_value({tag, " remainder"}, 64'(r8), 64'(er));
        check_value({tag, " div_by_zero"}, 64'(dz8), 64'(edz));
        tick();
        check_value({tag, " done_pulse_end"}, 64'(done8), 64'd0);
    endtask

    task automatic run24(input string tag, input logic [23:0] a, input logic [23:0] b,
                         input logic [23:0] eq, input logic [23:0] er, input logic edz,
                         input int elat);
        int cnt;
        a24 = a; b24 = b; s24 = 1'b1;
        tick();
        s24 = 1'b0;
        cnt = 0;
        while (!done24 && cnt < 60) begin
            tick();
            cnt++;
        end
        check_value({tag, " latency"}, 64'(cnt), 64'(elat));
        check_value({tag, " quotient"}, 64'(q24), 64'(eq));
        check_value({tag, " remainder"}, 64'(r24), 64'(er));
        check_value({tag, " div_by_zero"}, 64'(dz24), 64'(edz));
    endtask

    task automatic wait_done8(output int c);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!done8 && k < 60);
        c = done8 ? cyc : -1;
    endtask

    initial begin
        int t1, t2, t3;
        int dseen;

        reset = 1'b0;
        s8 = 1'b0; a8 = '0; b8 = '0;
        s24 = 1'b0; a24 = '0; b24 = '0;
        repeat (2) tick();
        check_value("rst busy", 64'(busy8), 64'd0);
        check_value("rst done", 64'(done8), 64'd0);
        check_value("rst quotient", 64'(q8), 64'd0);
        check_value("rst remainder", 64'(r8), 64'd0);
        check_value("rst div_by_zero", 64'(dz8), 64'd0);
        check_value("rst busy24", 64'(busy24), 64'd0);
        reset = 1'b1;
        tick();

        // Basic divides
        run8("100/7",   8'd100, 8'd7,   8'd14,  8'd2, 1'b0, 9);
        run8("5/9",     8'd5,   8'd9,   8'd0,   8'd5, 1'b0, 9);
        run8("255/1",   8'd255, 8'd1,   8'd255, 8'd0, 1'b0, 9);
        run8("255/255", 8'd255, 8'd255, 8'd1,   8'd0, 1'b0, 9);

        // Results hold while idle even with new values on the operand pins
        a8 = 8'h33; b8 = 8'h02;
        repeat (3) tick();
        check_value("hold quotient", 64'(q8), 64'd1);
        check_value("hold remainder", 64'(r8), 64'd0);

        // Divide by zero, then a normal op clears the flag
        run8("37/0", 8'd37, 8'd0, 8'hFF, 8'd37, 1'b1, 1);
        run8("10/3", 8'd10, 8'd3, 8'd3,  8'd1,  1'b0, 9);

        // Start held high across three ops, operands disturbed mid-CALC
        s8 = 1'b1; a8 = 8'd100; b8 = 8'd7;
        tick();
        repeat (3) tick();
        a8 = 8'h11; b8 = 8'h01;
        wait_done8(t1);
        check_value("b2b1 quotient", 64'(q8), 64'd14);
        check_value("b2b1 remainder", 64'(r8), 64'd2);
        a8 = 8'd50; b8 = 8'd6;
        repeat (4) tick();
        a8 = 8'h11; b8 = 8'h01;
        wait_done8(t2);
        check_value("b2b2 quotient", 64'(q8), 64'd8);
        check_value("b2b2 remainder", 64'(r8), 64'd2);
        a8 = 8'd77; b8 = 8'd5;
        repeat (4) tick();
        a8 = 8'h11; b8 = 8'h01;
        wait_done8(t3);
        s8 = 1'b0;
        check_value("b2b3 quotient", 64'(q8), 64'd15);
        check_value("b2b3 remainder", 64'(r8), 64'd2);
        check_value("b2b spacing12", 64'(t2 - t1), 64'd10);
        check_value("b2b spacing23", 64'(t3 - t2), 64'd10);
        tick();

        // Reset during the fourth CALC cycle
        a8 = 8'd100; b8 = 8'd7; s8 = 1'b1;
        tick();
        s8 = 1'b0;
        repeat (3) tick();
        check_value("abort busy_before", 64'(busy8), 64'd1);
        reset = 1'b0;
        #1;
        check_value("abort busy", 64'(busy8), 64'd0);
        check_value("abort done", 64'(done8), 64'd0);
        check_value("abort quotient", 64'(q8), 64'd0);
        check_value("abort remainder", 64'(r8), 64'd0);
        check_value("abort div_by_zero", 64'(dz8), 64'd0);
        dseen = 0;
        repeat (2) begin
            tick();
            if (done8) dseen++;
        end
        reset = 1'b1;
        repeat (15) begin
            tick();
            if (done8) dseen++;
        end
        check_value("abort no_done", 64'(dseen), 64'd0);
        run8("200/13", 8'd200, 8'd13, 8'd15, 8'd5, 1'b0, 9);

        // Wide instance
        run24("w24 FFFFFF/3", 24'hFFFFFF, 24'h000003, 24'h555555, 24'h000000, 1'b0, 25);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
